// File: rtl/vga_sync_monitor_if.sv
// Bundle of the sync/colour stream under test and the monitor's results.
// The source side (pong top or bench) uses master; the monitor uses slave.
interface vga_sync_monitor_if;
  logic        p_tick;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        locked;
  logic        h_err;
  logic        v_err;
  logic        frame_done;
  logic [15:0] frame_sig;
  logic [15:0] frame_count;

  modport master (
    output p_tick, hsync, vsync, rgb,
    input  x, y, video_on, locked, h_err, v_err, frame_done, frame_sig, frame_count
  );

  modport slave (
    input  p_tick, hsync, vsync, rgb,
    output x, y, video_on, locked, h_err, v_err, frame_done, frame_sig, frame_count
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Recovers pixel position from hsync/vsync edges, locks onto the frame timing and
// signs the active-area RGB per frame. VGA_MON_PIXEL_PROBE_EN adds a one-pixel colour probe.
module vga_sync_monitor #(
  parameter int H_DISPLAY        = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_DISPLAY        = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int RGB_DELAY        = 1,
  parameter int LOCK_FRAMES      = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef VGA_MON_PIXEL_PROBE_EN
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [11:0] probe_rgb,
`endif
  vga_sync_monitor_if.slave bus
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_MAX     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LOAD    = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] V_LOAD    = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] H_ACT     = 10'(H_DISPLAY);
  localparam logic [9:0] V_ACT     = 10'(V_DISPLAY);
  localparam logic [7:0] GOOD_LOCK = 8'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  good_reg, good_next, good_inc;
  logic        hs_prev_reg, vs_prev_reg;
  logic        hs_act, vs_act, hs_edge, vs_edge;
  logic [9:0]  h_cnt_reg, v_cnt_reg, h_inc, h_next, v_inc, v_next;
  logic        h_wrap, h_mis, v_mis, mis_any;
  logic        bad_reg, h_err_reg, v_err_reg, frame_done_reg;
  logic [15:0] acc_reg, frame_sig_reg, frame_count_reg;
  logic [19:0] pos_now, dly_pos;
  logic        dly_active, sig_en, frame_end, locked;

  // Horizontal step is resolved first so the vertical check sees the post-wrap line count.
  always_comb begin
    hs_act    = (SYNC_ACTIVE_HIGH != 0) ? bus.hsync : ~bus.hsync;
    vs_act    = (SYNC_ACTIVE_HIGH != 0) ? bus.vsync : ~bus.vsync;
    hs_edge   = bus.p_tick & hs_act & ~hs_prev_reg;
    vs_edge   = bus.p_tick & vs_act & ~vs_prev_reg;
    h_inc     = (h_cnt_reg == H_MAX) ? 10'd0 : h_cnt_reg + 10'd1;
    h_wrap    = (h_cnt_reg == H_MAX) & ~hs_edge;
    h_next    = hs_edge ? H_LOAD : h_inc;
    h_mis     = hs_edge & (h_inc != H_LOAD);
    v_inc     = h_wrap ? ((v_cnt_reg == V_MAX) ? 10'd0 : v_cnt_reg + 10'd1) : v_cnt_reg;
    v_next    = vs_edge ? V_LOAD : v_inc;
    v_mis     = vs_edge & (v_inc != V_LOAD);
    mis_any   = h_mis | v_mis;
    good_inc  = good_reg + 8'd1;
    pos_now   = {v_next, h_next};
    dly_active = (dly_pos[9:0] < H_ACT) && (dly_pos[19:10] < V_ACT);
    sig_en    = (state_reg == LOCKED) & dly_active;
    frame_end = (state_reg == LOCKED) & vs_edge & ~mis_any;
  end

  // Position delay line so the signature sees the pixel that the lagging rgb belongs to.
  generate
    if (RGB_DELAY == 0) begin : g_no_delay
      assign dly_pos = pos_now;
    end else begin : g_delay
      logic [19:0] pipe_reg [RGB_DELAY];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < RGB_DELAY; i++) pipe_reg[i] <= '0;
        end else if (bus.p_tick) begin
          pipe_reg[0] <= pos_now;
          for (int i = 1; i < RGB_DELAY; i++) pipe_reg[i] <= pipe_reg[i-1];
        end
      end
      assign dly_pos = pipe_reg[RGB_DELAY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SEARCH;
      good_reg  <= '0;
    end else if (bus.p_tick) begin
      state_reg <= state_next;
      good_reg  <= good_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    case (state_reg)
      SEARCH: begin
        if (vs_edge) begin
          state_next = ACQUIRE;
          good_next  = '0;
        end
      end
      ACQUIRE: begin
        if (mis_any) begin
          good_next = '0;
        end else if (vs_edge) begin
          if (bad_reg) begin
            good_next = '0;
          end else begin
            good_next = good_inc;
            if (good_inc >= GOOD_LOCK) state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (mis_any) state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    locked          = (state_reg == LOCKED);
    bus.locked      = locked;
    bus.x           = locked ? h_cnt_reg : 10'd0;
    bus.y           = locked ? v_cnt_reg : 10'd0;
    bus.video_on    = locked && (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
    bus.h_err       = h_err_reg;
    bus.v_err       = v_err_reg;
    bus.frame_done  = frame_done_reg;
    bus.frame_sig   = frame_sig_reg;
    bus.frame_count = frame_count_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev_reg     <= 1'b0;
      vs_prev_reg     <= 1'b0;
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      bad_reg         <= 1'b0;
      h_err_reg       <= 1'b0;
      v_err_reg       <= 1'b0;
      acc_reg         <= '0;
      frame_sig_reg   <= '0;
      frame_count_reg <= '0;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (bus.p_tick) begin
        hs_prev_reg <= hs_act;
        vs_prev_reg <= vs_act;
        h_cnt_reg   <= h_next;
        v_cnt_reg   <= v_next;
        if ((state_reg != SEARCH) && h_mis) h_err_reg <= 1'b1;
        if ((state_reg != SEARCH) && v_mis) v_err_reg <= 1'b1;
        // Remembers a bad line since the last vsync edge, so ACQUIRE does not count that frame.
        bad_reg <= vs_edge ? 1'b0 : (bad_reg | h_mis);
        if (frame_end) begin
          frame_sig_reg   <= acc_reg;
          acc_reg         <= '0;
          frame_done_reg  <= 1'b1;
          frame_count_reg <= frame_count_reg + 16'd1;
        end else if (state_reg != LOCKED) begin
          acc_reg <= '0;
        end else if (sig_en) begin
          acc_reg <= {acc_reg[14:0], acc_reg[15]} ^ {4'h0, bus.rgb};
        end
      end
    end
  end

`ifdef VGA_MON_PIXEL_PROBE_EN
  logic [11:0] probe_rgb_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      probe_rgb_reg <= '0;
    end else if (bus.p_tick && locked && (dly_pos[9:0] == probe_x) && (dly_pos[19:10] == probe_y)) begin
      probe_rgb_reg <= bus.rgb;
    end
  end
  assign probe_rgb = probe_rgb_reg;
`endif
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Drives a reduced-geometry raster into vga_sync_monitor and scores lock, position,
// error flags and per-frame signatures against a bench-side raster model.
module tb_vga_sync_monitor;
  localparam int HD = 16, HF = 2, HS = 4, HB = 3;
  localparam int VD = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int SHORT_V = 3;
  localparam int PX = 10, PY = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  vga_sync_monitor_if bus();
`ifdef VGA_MON_PIXEL_PROBE_EN
  logic [9:0]  probe_x = 10'(PX);
  logic [9:0]  probe_y = 10'(PY);
  logic [11:0] probe_rgb;
`endif

  vga_sync_monitor #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_HIGH(1), .RGB_DELAY(1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef VGA_MON_PIXEL_PROBE_EN
    .probe_x(probe_x),
    .probe_y(probe_y),
    .probe_rgb(probe_rgb),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int hc = 0, vc = 0, mode = 0, good_edges = 0, edge_cnt = 0, cnt_model = 0;
  bit exp_herr = 0, short_req = 0, short_pending = 0;
  logic [11:0] col_prev = '0;
  logic [15:0] acc_model = '0;
  logic [15:0] sig_a;
  logic [15:0] sb[$];
  logic [11:0] pat [HD*VD];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (h=%0d v=%0d)", tag, got, exp, hc, vc);
    end
  endtask

  function automatic logic [11:0] colour(int h, int v);
    if (mode == 0) return 12'h000;
    return pat[v*HD + h];
  endfunction

  task automatic check_zero_outputs();
    check("rst_locked", bus.locked, 0);
    check("rst_x", bus.x, 0);
    check("rst_y", bus.y, 0);
    check("rst_video_on", bus.video_on, 0);
    check("rst_h_err", bus.h_err, 0);
    check("rst_v_err", bus.v_err, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_frame_sig", bus.frame_sig, 0);
    check("rst_frame_count", bus.frame_count, 0);
`ifdef VGA_MON_PIXEL_PROBE_EN
    check("rst_probe_rgb", probe_rgb, 0);
`endif
  endtask

  // One pixel tick: p_tick high for one clk, idle for one clk.
  task automatic step();
    bit act, hs_e, vs_e, exp_done, exp_locked;
    logic [11:0] col;
    logic [15:0] exp_sig;
    act  = (hc < HD) && (vc < VD);
    col  = act ? colour(hc, vc) : 12'h000;
    hs_e = (hc == HD + HF);
    vs_e = (vc == VD + VF) && (hc == 0);
    bus.hsync  = (hc >= HD + HF) && (hc < HD + HF + HS);
    bus.vsync  = (vc >= VD + VF) && (vc < VD + VF + VS);
    bus.rgb    = col_prev;
    bus.p_tick = 1'b1;
    exp_done = 0;
    if (hs_e && short_pending) begin
      short_pending = 0;
      good_edges = 0;
      exp_herr = 1;
    end
    if (vs_e) begin
      edge_cnt++;
      if (good_edges < 3) good_edges++;
      if (good_edges >= 3) begin
        sb.push_back(acc_model);
        exp_done = 1;
      end
      acc_model = '0;
    end else if (act) begin
      acc_model = {acc_model[14:0], acc_model[15]} ^ {4'h0, col};
    end
    exp_locked = (good_edges >= 2);
    @(posedge clk);
    #1;
    bus.p_tick = 1'b0;
    $display("tick h=%0d v=%0d locked=%0d x=%0d y=%0d von=%0d done=%0d", hc, vc,
             bus.locked, bus.x, bus.y, bus.video_on, bus.frame_done);
    check("locked", bus.locked, exp_locked);
    check("h_err", bus.h_err, exp_herr);
    check("v_err", bus.v_err, 0);
    if (!exp_locked) begin
      check("x_unlocked", bus.x, 0);
      check("y_unlocked", bus.y, 0);
      check("video_on_unlocked", bus.video_on, 0);
    end else if (!short_pending) begin
      check("x", bus.x, hc);
      check("y", bus.y, vc);
      check("video_on", bus.video_on, act);
    end
    check("frame_done", bus.frame_done, exp_done);
    if ((bus.frame_done || exp_done) && sb.size() > 0) begin
      exp_sig = sb.pop_front();
      cnt_model++;
      check("frame_sig", bus.frame_sig, exp_sig);
      check("frame_count", bus.frame_count, cnt_model);
    end
    @(posedge clk);
    #1;
    check("done_pulse", bus.frame_done, 0);
    col_prev = col;
    if (short_req && vc == SHORT_V && hc == HT - 2) begin
      short_req = 0;
      short_pending = 1;
      hc = 0;
      vc = (vc == VT - 1) ? 0 : vc + 1;
    end else if (hc == HT - 1) begin
      hc = 0;
      vc = (vc == VT - 1) ? 0 : vc + 1;
    end else begin
      hc++;
    end
  endtask

  task automatic run_edges(input int n);
    int target;
    target = edge_cnt + n;
    for (int i = 0; i < (n + 1) * HT * VT && edge_cnt < target; i++) step();
  endtask

  task automatic run_to(input int h, input int v);
    for (int i = 0; i < HT * VT && !(hc == h && vc == v); i++) step();
  endtask

  initial begin
    bus.p_tick = 1'b0;
    bus.hsync  = 1'b0;
    bus.vsync  = 1'b0;
    bus.rgb    = '0;
    for (int i = 0; i < HD*VD; i++) pat[i] = 12'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs();
    reset = 1'b0;

    mode = 0;
    run_edges(3);
    check("first_count", bus.frame_count, 1);
    check("sig_zero", bus.frame_sig, 0);

    mode = 1;
    run_edges(1);
    sig_a = bus.frame_sig;
    run_edges(1);
    check("sig_repeat", bus.frame_sig, sig_a);

    for (int i = 0; i < HD*VD; i++) pat[i] = 12'($urandom);
    run_edges(1);
`ifdef VGA_MON_PIXEL_PROBE_EN
    check("probe_rgb", probe_rgb, pat[PY*HD + PX]);
`endif

    short_req = 1;
    run_edges(3);
    check("h_err_sticky", bus.h_err, 1);
    check("relocked", bus.locked, 1);

    run_to(7, 4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs();
    good_edges = 0;
    exp_herr   = 0;
    cnt_model  = 0;
    acc_model  = '0;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_edges(3);
    check("post_reset_count", bus.frame_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator: consumes hsync/vsync/rgb at the pixel tick and recovers pixel coordinates from the sync edges alone.
- Checks line and frame timing against the 640x480 geometry, runs a lock state machine, and produces a per-frame 16-bit signature of the active-area RGB.
- Sits beside the pong top level in simulation and on-board self-test, fed by the same hsync, vsync, rgb and pixel tick that drive the VGA connector.

Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, pixels from end of active to hsync leading edge
- H_SYNC, 96, hsync width
- H_BACK, 48, pixels from hsync trailing edge to next line
- V_DISPLAY, 480, active lines
- V_FRONT, 10, lines from end of active to vsync leading edge
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, lines after vsync
- SYNC_ACTIVE_HIGH, 1, 1 means sync asserted = 1
- RGB_DELAY, 1, p_ticks by which rgb lags sync/position (0..3)
- LOCK_FRAMES, 2, consecutive good vsync edges required to lock

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- p_tick  in  1  pixel enable, one clk wide, 25 MHz rate
- hsync  in  1  horizontal sync under test
- vsync  in  1  vertical sync under test
- rgb  in  12  pixel colour under test
- x  out  10  recovered column, valid when locked
- y  out  10  recovered row, valid when locked
- video_on  out  1  locked and recovered position in active area
- locked  out  1  timing lock achieved
- h_err  out  1  sticky: line-length or hsync-position mismatch
- v_err  out  1  sticky: frame-length or vsync-position mismatch
- frame_done  out  1  one-clk pulse when frame_sig updates
- frame_sig  out  16  signature of last complete locked frame
- frame_count  out  16  completed locked frames, wraps 0xFFFF -> 0

Behaviour:
- Reset: all outputs 0; counters 0; FSM SEARCH; RGB delay line cleared. Applies mid-frame or mid-lock with no residue.
- All sampling and updates occur only on clk edges with p_tick=1. Outputs register one clk after the qualifying p_tick.
- Leading edge = sync goes from inactive to active between consecutive p_tick samples.
- h_cnt (0..H_TOTAL-1, H_TOTAL=800): at an hsync leading edge, load H_DISPLAY+H_FRONT (656); otherwise increment, wrapping 799 -> 0. At the edge, if the incremented value != 656 and the FSM is not SEARCH, set h_err.
- v_cnt (0..V_TOTAL-1, V_TOTAL=525): increments when h_cnt wraps. At a vsync leading edge, load V_DISPLAY+V_FRONT (490); the prior expected value must be 490, else mismatch.
- FSM:
  - SEARCH: wait for a vsync leading edge, then enter ACQUIRE with good=0.
  - ACQUIRE: each vsync edge with no h or v mismatch since the previous edge increments good. good==LOCK_FRAMES-1 -> LOCKED. Any mismatch -> good=0 and stay in ACQUIRE.
  - LOCKED: any mismatch -> SEARCH, locked=0, and set the sticky flag (h_err or v_err) the same clk.
- Sticky flags clear only on reset.
- x=h_cnt and y=v_cnt when locked, else 0. video_on = locked & h_cnt<640 & v_cnt<480.
- Signature, applied per p_tick:
  - Condition: locked and the position delayed by RGB_DELAY ticks is active.
  - Update: acc <= {acc[14:0],acc[15]} ^ {4'h0,rgb}.
  - At a vsync leading edge in LOCKED: frame_sig<=acc, acc<=0, frame_done=1, frame_count+1.
  - Frames that end with a mismatch are discarded: no frame_done.
  - On entry to LOCKED, acc=0, so the first frame_done arrives one frame after lock.
- Simultaneous hsync and vsync edges: process horizontal first, then vertical, on the same tick.

Optional Feature:
- Macro VGA_MON_PIXEL_PROBE_EN.
- Defined: adds inputs probe_x[9:0] and probe_y[9:0], and output probe_rgb[12]. probe_rgb captures the (RGB_DELAY-aligned) rgb at that coordinate once per locked frame and holds it; reset value 0.
- Undefined: these ports and their logic are absent.

Test Plan:
- Ideal 800x525 timing, SYNC_ACTIVE_HIGH=1: locked=0 through first vsync edge, locked=1 one clk after the second vsync edge; first frame_done at the third edge; frame_count=1.
- Locked, rgb=12'h000 for the whole frame -> frame_sig=16'h0000. Two identical frames of random rgb -> equal frame_sig, frame_count increments by 1 per frame.
- Locked, one line shortened to 799 ticks -> h_err=1 and locked=0 at the next hsync edge; re-locks after LOCK_FRAMES good vsync edges; h_err stays 1.
- Locked: at the p_tick where h_cnt=0 and v_cnt=0, next clk x=0, y=0, video_on=1; at h_cnt=640 -> video_on=0; at v_cnt=480 -> video_on=0.
- reset asserted mid-frame while locked -> next clk all outputs 0, FSM SEARCH; lock again after 2 vsync edges.
- With VGA_MON_PIXEL_PROBE_EN, probe=(10,20), rgb=12'hABC only at that pixel (RGB_DELAY=1) -> probe_rgb=12'hABC after the frame.
